// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse_gen_out output-pulse generator.
// Holds the FSM state encoding, default widths and the effective-length rule.
package pulse_gen_pkg;

    localparam int unsigned W_DEF  = 16;
    localparam int unsigned DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    // A programmed length of zero still yields one cycle; callers hold W <= 32.
    function automatic logic [31:0] eff_len(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/pulse_gen_timer.sv
// Loadable down-counter that times both the HIGH and the GAP phases.
// zero_o flags the last cycle of the currently loaded interval.
module pulse_gen_timer #(
    parameter int unsigned W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen_out.sv
// Drives an external line with clean pulses of programmable high time and low gap.
// One request can wait in a pending slot; further requests while it is full are counted as drops.
module pulse_gen_out
    import pulse_gen_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          trig_in,
    input  logic [W-1:0]  width_in,
    input  logic [W-1:0]  gap_in,
    input  logic          drop_clr,
    output logic          dout,
    output logic          busy_o,
    output logic          pend_o,
    output logic          done_o,
    output logic [DW-1:0] drop_cnt_o,
    output state_e        state_o
);

    state_e         state_q, state_d;
    logic [W-1:0]   act_gap_q, act_gap_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   pend_w_q, pend_w_d;
    logic [W-1:0]   pend_g_q, pend_g_d;
    logic [DW-1:0]  drop_q, drop_d;
    logic           dout_q, dout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           drop_inc;
    logic           tmr_load;
    logic [W-1:0]   tmr_val;
    logic [W-1:0]   tmr_cnt;
    logic           tmr_zero;
    logic [W-1:0]   cur_w;
    logic [W-1:0]   cur_g;

    assign cur_w = W'(eff_len(32'(width_in)));
    assign cur_g = W'(eff_len(32'(gap_in)));

    pulse_gen_timer #(.W(W)) u_timer (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load_i     (tmr_load),
        .en_i       (state_q != IDLE),
        .load_val_i (tmr_val),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        act_gap_d = act_gap_q;
        pend_d    = pend_q;
        pend_w_d  = pend_w_q;
        pend_g_d  = pend_g_q;
        drop_inc  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig_in) begin
                    state_d   = HIGH;
                    act_gap_d = cur_g;
                    tmr_load  = 1'b1;
                    tmr_val   = cur_w - W'(1);
                end
            end
            HIGH, GAP: begin
                if ((state_q == GAP) && tmr_zero) begin
                    // Exit cycle: a queued request wins, and a fresh trigger refills its slot.
                    if (pend_q) begin
                        state_d   = HIGH;
                        act_gap_d = pend_g_q;
                        tmr_load  = 1'b1;
                        tmr_val   = pend_w_q - W'(1);
                        pend_d    = trig_in;
                        if (trig_in) begin
                            pend_w_d = cur_w;
                            pend_g_d = cur_g;
                        end
                    end else if (trig_in) begin
                        state_d   = HIGH;
                        act_gap_d = cur_g;
                        tmr_load  = 1'b1;
                        tmr_val   = cur_w - W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (state_q == HIGH) begin
                        if (tmr_zero) begin
                            state_d  = GAP;
                            tmr_load = 1'b1;
                            tmr_val  = act_gap_q - W'(1);
                            done_d   = (act_gap_q == W'(1));
                        end
                    end else begin
                        done_d = (tmr_cnt == W'(1));
                    end
                    if (trig_in) begin
                        if (!pend_q) begin
                            pend_d   = 1'b1;
                            pend_w_d = cur_w;
                            pend_g_d = cur_g;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop_clr) begin
            drop_d = '0;
        end else if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + DW'(1);
        end else begin
            drop_d = drop_q;
        end

        dout_d = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            act_gap_q <= '0;
            pend_q    <= 1'b0;
            pend_w_q  <= '0;
            pend_g_q  <= '0;
            drop_q    <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_gap_q <= act_gap_d;
            pend_q    <= pend_d;
            pend_w_q  <= pend_w_d;
            pend_g_q  <= pend_g_d;
            drop_q    <= drop_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dout       = dout_q;
    assign busy_o     = busy_q;
    assign pend_o     = pend_q;
    assign done_o     = done_q;
    assign drop_cnt_o = drop_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pulse_gen_out.sv
// Bench for pulse_gen_out: directed scenarios plus random traffic against a timeline model.
// The model tracks each pulse by its start edge and effective lengths, plus a FIFO of queued requests.
module tb_pulse_gen_out;
    import pulse_gen_pkg::*;

    localparam int W  = 16;
    localparam int DW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          trig_in = 1'b0;
    logic [W-1:0]  width_in = '0;
    logic [W-1:0]  gap_in = '0;
    logic          drop_clr = 1'b0;
    logic          dout;
    logic          busy_o;
    logic          pend_o;
    logic          done_o;
    logic [DW-1:0] drop_cnt_o;
    state_e        state_o;

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    pulse_gen_out #(.W(W), .DW(DW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .trig_in    (trig_in),
        .width_in   (width_in),
        .gap_in     (gap_in),
        .drop_clr   (drop_clr),
        .dout       (dout),
        .busy_o     (busy_o),
        .pend_o     (pend_o),
        .done_o     (done_o),
        .drop_cnt_o (drop_cnt_o),
        .state_o    (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_busy = 1'b0;
    int            m_t0 = 0;
    int            m_w = 1;
    int            m_g = 1;
    int            m_drops = 0;
    int            pq_w[$];
    int            pq_g[$];
    logic [W-1:0]  exp_q[$];
    int            run_len = 0;

    function automatic int eff(input logic [W-1:0] x);
        return (x == '0) ? 1 : int'(x);
    endfunction

    task automatic m_start(input int w, input int g);
        m_busy = 1'b1;
        m_t0   = cyc;
        m_w    = w;
        m_g    = g;
        exp_q.push_back(W'(w));
    endtask

    task automatic m_queue(input int w, input int g);
        pq_w.push_back(w);
        pq_g.push_back(g);
    endtask

    task automatic model_edge();
        int w;
        int g;
        if (!aresetn) begin
            m_busy  = 1'b0;
            m_drops = 0;
            pq_w.delete();
            pq_g.delete();
            exp_q.delete();
            run_len = 0;
            return;
        end
        if (!m_busy) begin
            if (trig_in) m_start(eff(width_in), eff(gap_in));
        end else if (cyc == m_t0 + m_w + m_g) begin
            if (pq_w.size() > 0) begin
                w = pq_w.pop_front();
                g = pq_g.pop_front();
                m_start(w, g);
                if (trig_in) m_queue(eff(width_in), eff(gap_in));
            end else if (trig_in) begin
                m_start(eff(width_in), eff(gap_in));
            end else begin
                m_busy = 1'b0;
            end
        end else if (trig_in) begin
            if (pq_w.size() == 0) m_queue(eff(width_in), eff(gap_in));
            else if (m_drops < (1 << DW) - 1) m_drops++;
        end
        if (drop_clr) m_drops = 0;
    endtask

    // ---------------- sampling / scoreboard ----------------
    task automatic sample();
        int     off;
        bit     e_dout;
        bit     e_done;
        state_e e_state;
        off     = cyc - m_t0;
        e_dout  = m_busy && (off < m_w);
        e_done  = m_busy && (off == m_w + m_g - 1);
        e_state = !m_busy ? IDLE : (e_dout ? HIGH : GAP);
        check("dout",  32'(dout),       32'(e_dout));
        check("busy",  32'(busy_o),     32'(m_busy));
        check("pend",  32'(pend_o),     32'(pq_w.size()));
        check("done",  32'(done_o),     32'(e_done));
        check("drops", 32'(drop_cnt_o), 32'(m_drops));
        check("state", 32'(state_o),    32'(e_state));
        if (dout === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            if (exp_q.size() == 0) check("width_unexpected", 32'(run_len), 32'd0);
            else check("width", 32'(run_len), 32'(exp_q.pop_front()));
            run_len = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit t, input logic [W-1:0] w, input logic [W-1:0] g,
                        input bit clr, input bit rn);
        trig_in  = t;
        width_in = w;
        gap_in   = g;
        drop_clr = clr;
        aresetn  = rn;
        @(posedge aclk);
        cyc++;
        model_edge();
        #1;
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom_range(0, 9)), W'($urandom_range(0, 9)), 1'b0, 1'b1);
    endtask

    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(5);
        // basic 3/2 pulse
        step(1'b1, 16'd3, 16'd2, 1'b0, 1'b1);
        idle(8);
        // zero lengths become one cycle each
        step(1'b1, 16'd0, 16'd0, 1'b0, 1'b1);
        idle(4);
        // queued request runs back to back with no idle cycle
        step(1'b1, 16'd4, 16'd3, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 16'd5, 16'd1, 1'b0, 1'b1);
        idle(16);
        // drops, then clear wins over a simultaneous drop
        step(1'b1, 16'd6, 16'd2, 1'b0, 1'b1);
        step(1'b1, 16'd2, 16'd2, 1'b0, 1'b1);
        step(1'b1, 16'd3, 16'd3, 1'b0, 1'b1);
        step(1'b1, 16'd1, 16'd1, 1'b0, 1'b1);
        step(1'b1, 16'd1, 16'd1, 1'b1, 1'b1);
        idle(20);
        // reset in the second HIGH cycle with a request queued
        step(1'b1, 16'd4, 16'd4, 1'b0, 1'b1);
        step(1'b1, 16'd2, 16'd2, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 16'd3, 16'd2, 1'b0, 1'b1);
        idle(8);
        // trigger on the done cycle keeps busy asserted
        step(1'b1, 16'd2, 16'd2, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 16'd3, 16'd1, 1'b0, 1'b1);
        idle(8);
        // random traffic with varying trigger density
        for (int blk = 0; blk < 12; blk++) begin
            int dens;
            dens = $urandom_range(1, 8);
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(0, 9) < dens),
                     W'($urandom_range(0, 6)), W'($urandom_range(0, 5)),
                     ($urandom_range(0, 49) == 0),
                     ($urandom_range(0, 499) != 0));
            end
        end
        idle(40);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
